// File: rtl/puf_response_sampler.sv
// Multi-channel PUF response sampler: synchronises D, majority-votes SAMPLES strobes per channel, flags non-unanimous channels.
// Valid pulses the cycle after the SAMPLES-th accepted strobe; no backpressure, Start/Strobe outside their states are dropped.
module puf_response_sampler #(
    parameter int WIDTH       = 8,
    parameter int SAMPLES     = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             Start,
    input  logic             Clear,
    input  logic             Strobe,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Unstable,
    output logic             Valid,
    output logic             Busy
);

    localparam int CNT_W = $clog2(SAMPLES + 1);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(SAMPLES / 2);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SAMPLES);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_r;
    logic [WIDTH-1:0]                  ds;

    logic [CNT_W-1:0]            sample_cnt, cnt_nxt, cnt_inc;
    logic [WIDTH-1:0][CNT_W-1:0] ones, ones_nxt, ones_inc;
    logic [WIDTH-1:0]            q_new, u_new;
    logic                        load_result;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= D;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    assign ds = sync_r[SYNC_STAGES-1];

    // Result is computed from the post-increment counts so it can be loaded on the final strobe edge.
    always_comb begin
        cnt_inc  = sample_cnt + CNT_W'(1);
        ones_inc = '0;
        q_new    = '0;
        u_new    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_inc[i] = ones[i] + CNT_W'(ds[i]);
            q_new[i]    = ones_inc[i] > HALF;
            u_new[i]    = (ones_inc[i] != '0) && (ones_inc[i] != FULL);
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = sample_cnt;
        ones_nxt    = ones;
        load_result = 1'b0;
        if (Clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            ones_nxt  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state_nxt = COLLECT;
                        cnt_nxt   = '0;
                        ones_nxt  = '0;
                    end
                end
                COLLECT: begin
                    if (Strobe) begin
                        cnt_nxt  = cnt_inc;
                        ones_nxt = ones_inc;
                        if (cnt_inc == FULL) begin
                            state_nxt   = DONE;
                            load_result = 1'b1;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            sample_cnt <= '0;
            ones       <= '0;
            Q          <= '0;
            Unstable   <= '0;
        end else begin
            state      <= state_nxt;
            sample_cnt <= cnt_nxt;
            ones       <= ones_nxt;
            if (load_result) begin
                Q        <= q_new;
                Unstable <= u_new;
            end
        end
    end

    assign Valid = (state == DONE);
    assign Busy  = (state != IDLE);

endmodule
